// File: rtl/ret_addr_stack_if.sv
// Return-address stack port bundle.
// The PC unit drives the master side. The stack drives the slave side.
interface ret_addr_stack_if #(
  parameter int AW    = 32,
  parameter int PTR_W = 3
);
  logic             push;
  logic             pop;
  logic             flush;
  logic [AW-1:0]    push_addr;
  logic [AW-1:0]    top_addr;
  logic             top_valid;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, flush, push_addr,
    input  top_addr, top_valid, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, push_addr,
    output top_addr, top_valid, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/ret_addr_stack.sv
// Return-address stack: a circular buffer of DEPTH return PCs.
// The top entry is read combinationally so the PC mux can use it in the pop cycle.
// tos and count then move on the following edge.
// A push while full overwrites the oldest entry. A sticky flag records each such loss.
module ret_addr_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int AW    = 32
) (
  input logic            clk,
  input logic            rst_n,
  ret_addr_stack_if.slave ras
);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PTR_W-1:0] tos_inc;
  logic [PTR_W-1:0] tos_dec;
  logic [AW-1:0]    wr_addr;
  logic             is_full;
  logic             is_empty;

  assign tos_inc  = tos_q + PTR_W'(1);
  assign tos_dec  = tos_q - PTR_W'(1);
  // Return PCs are word aligned, so the low bits are dropped on store.
  assign wr_addr  = {ras.push_addr[AW-1:2], 2'b00};
  assign is_full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign is_empty = (cnt_q == '0);

  // Next-state: flush wins, then push/pop combinations.
  always_comb begin
    mem_d = mem_q;
    tos_d = tos_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (ras.flush) begin
      // Only the bookkeeping is cleared. Stale entries are never read past count.
      tos_d = '0;
      cnt_d = '0;
    end else if (ras.push && ras.pop && !is_empty) begin
      // Return straight into a call replaces the top in place.
      mem_d[tos_q] = wr_addr;
    end else if (ras.push) begin
      // Push while full wraps onto the oldest slot, which is tos+1.
      tos_d          = tos_inc;
      mem_d[tos_inc] = wr_addr;
      if (is_full) ovf_d = 1'b1;
      else         cnt_d = cnt_q + 1'b1;
      // A pop on empty paired with a push still counts as an underflow.
      if (ras.pop) unf_d = 1'b1;
    end else if (ras.pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        tos_d = tos_dec;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // State registers. Async reset also clears storage so that top_addr starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ras.top_addr  = mem_q[tos_q];
  assign ras.top_valid = !is_empty;
  assign ras.count     = cnt_q;
  assign ras.full      = is_full;
  assign ras.empty     = is_empty;
  assign ras.overflow  = ovf_q;
  assign ras.underflow = unf_q;

endmodule
